// File: rtl/mac_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_seq_pkg
// Purpose  : Shared types and constants for the MAC job sequencer: the FSM
//            state encoding, operand/accumulator widths and the zero operand.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tpu_seq_pkg;

    localparam int OP_W   = 8;
    localparam int ACC_W  = 34;
    localparam int HALF_W = 17;

    // Minifloat 0x00 multiplies to exactly zero, so it is the idle operand.
    localparam logic [OP_W-1:0] ZERO_OP = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_STREAM  = 3'd2,
        S_READ_LO = 3'd3,
        S_READ_HI = 3'd4,
        S_DONE    = 3'd5
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_sequencer_if
// Purpose  : Bundles the command, operand and result handshakes together
//            with the MAC control/return signals of one sequencer instance.
// Ports    : cmd_*  job command (pair count minus one)
//            op_*   operand pair stream
//            res_*  accumulated result and sticky error
//            mac_*  MAC clear, operands, half-select, selected half, error
//            modport slave  : sequencer view
//            modport master : environment view (source, sink and MAC)
// Revision : 1.0 - initial release
// ============================================================================
interface mac_sequencer_if
    import tpu_seq_pkg::*;
#(
    parameter int LEN_W = 8
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;

    logic              op_valid;
    logic              op_ready;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;

    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic              res_error;

    logic              mac_clear;
    logic [OP_W-1:0]   mac_a;
    logic [OP_W-1:0]   mac_b;
    logic              mac_hl;
    logic [HALF_W-1:0] mac_out;
    logic              mac_error;

    modport slave (
        input  cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
               mac_out, mac_error,
        output cmd_ready, op_ready, res_valid, res_data, res_error,
               mac_clear, mac_a, mac_b, mac_hl
    );

    modport master (
        output cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
               mac_out, mac_error,
        input  cmd_ready, op_ready, res_valid, res_data, res_error,
               mac_clear, mac_a, mac_b, mac_hl
    );

endinterface
`default_nettype wire

// File: rtl/mac_sequencer_pair_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_pair_counter
// Purpose  : Loadable down-counter of remaining operand pairs with a
//            terminal-count flag (count == 0).
// Ports    : clk, reset (async, active-low)
//            load / load_val : load the counter
//            dec             : decrement by one
//            tc              : counter is zero
// Revision : 1.0 - initial release
// ============================================================================
module seq_pair_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [LEN_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            // The last pair is taken at zero; holding there avoids a wrap.
            r_count <= r_count - 1'b1;
        end
    end

    assign tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_sequencer
// Purpose  : Runs one minifloat MAC through complete dot-product jobs:
//            clear, stream cmd_len+1 pairs, read the 34-bit sum back in two
//            17-bit halves, and present it with a sticky overflow flag.
// Ports    : clk   - clock
//            reset - asynchronous active-low reset, returns to IDLE
//            bus   - mac_sequencer_if.slave (cmd/op/res handshakes, MAC ctl)
// Revision : 1.0 - initial release
// ============================================================================
module mac_sequencer
    import tpu_seq_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    mac_sequencer_if.slave     bus
);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [ACC_W-1:0]  r_res_data;
    logic              r_res_error;
    logic              w_op_fire;
    logic              w_cmd_fire;
    logic              w_last_pair;

    logic              w_cmd_ready;
    logic              w_op_ready;
    logic              w_res_valid;
    logic              w_mac_clear;
    logic              w_mac_hl;
    logic [OP_W-1:0]   w_mac_a;
    logic [OP_W-1:0]   w_mac_b;

    assign w_cmd_fire = (r_state == S_IDLE)   && bus.cmd_valid;
    assign w_op_fire  = (r_state == S_STREAM) && bus.op_valid;

    seq_pair_counter #(
        .LEN_W    (LEN_W)
    ) u_pair_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (w_cmd_fire),
        .load_val (bus.cmd_len),
        .dec      (w_op_fire),
        .tc       (w_last_pair)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (bus.cmd_valid) w_next_state = S_CLEAR;
            S_CLEAR:   w_next_state = S_STREAM;
            S_STREAM:  if (w_op_fire && w_last_pair) w_next_state = S_READ_LO;
            S_READ_LO: w_next_state = S_READ_HI;
            S_READ_HI: w_next_state = S_DONE;
            S_DONE:    if (bus.res_ready) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    // The MAC adds a product every cycle, so operands are forced to the
    // zero minifloat whenever no pair is being handed over.
    always_comb begin
        w_cmd_ready = (r_state == S_IDLE);
        w_op_ready  = (r_state == S_STREAM);
        w_mac_clear = (r_state == S_CLEAR);
        w_mac_hl    = (r_state == S_READ_HI);
        w_res_valid = (r_state == S_DONE);
        w_mac_a     = ZERO_OP;
        w_mac_b     = ZERO_OP;
        if (w_op_fire) begin
            w_mac_a = bus.op_a;
            w_mac_b = bus.op_b;
        end
    end

    // ---------------- result capture and sticky error ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res_data  <= '0;
            r_res_error <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR:   r_res_error <= 1'b0;
                S_STREAM:  if (w_op_fire) r_res_error <= r_res_error | bus.mac_error;
                S_READ_LO: r_res_data[HALF_W-1:0]     <= bus.mac_out;
                S_READ_HI: r_res_data[ACC_W-1:HALF_W] <= bus.mac_out;
                default:   ;
            endcase
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.op_ready  = w_op_ready;
    assign bus.res_valid = w_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_error = r_res_error;
    assign bus.mac_clear = w_mac_clear;
    assign bus.mac_hl    = w_mac_hl;
    assign bus.mac_a     = w_mac_a;
    assign bus.mac_b     = w_mac_b;

endmodule
`default_nettype wire

// File: doc/mac_sequencer.md
# mac_sequencer

Controller that sequences the 8-bit minifloat multiply-accumulate unit through complete dot-product jobs. It accepts a job command (pair count), clears the MAC accumulator, streams operand pairs into it under a valid/ready handshake, and reads back the 34-bit sum in two 17-bit halves via the MAC's half-select. It returns the sum and a sticky overflow flag on a result handshake. It sits between the operand source (buffer/array feeder) and one MAC instance and owns that instance's clear, operand, and half-select inputs.

## Interface
- LEN_W, 8: width of cmd_len; a job is cmd_len+1 pairs (1..2^LEN_W)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; returns the block to IDLE
- cmd_valid / cmd_ready  in / out  1 / 1  job command handshake
- cmd_len  in  LEN_W  pair count minus one
- op_valid / op_ready  in / out  1 / 1  operand pair handshake
- op_a, op_b  in  8 / 8  minifloat operands: {sign, exp[3:0], mant[2:0]}
- res_valid / res_ready  out / in  1 / 1  result handshake
- res_data  out  34  two's-complement accumulated sum
- res_error  out  1  OR of MAC error over all accepted pairs
- mac_clear  out  1  MAC synchronous accumulator clear (active-high)
- mac_a, mac_b  out  8 / 8  MAC operand inputs
- mac_hl  out  1  MAC half-select: 0 selects acc[16:0], 1 selects acc[33:17]
- mac_out  in  17  MAC selected half
- mac_error  in  1  MAC shifter overflow for the current operands

## Operation
- The MAC accumulates on every clk edge, so mac_a/mac_b = 8'h00 in every cycle in which no pair is handshaked (the product is exactly 0).
- States: IDLE, CLEAR, STREAM, READ_LO, READ_HI, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_len into the remaining-pair counter and go to CLEAR.
- CLEAR: mac_clear=1 for exactly one cycle; clear the sticky error; go to STREAM.
- STREAM: op_ready=1; mac_a/mac_b = op_valid ? op_a/op_b : 0.
  - Each handshake decrements the counter and ORs mac_error into the sticky error.
  - The handshake with counter==0 moves the block to READ_LO.
  - op_valid low inserts a bubble; no count change.
- READ_LO: mac_hl=0; capture mac_out into res_data[16:0]; go to READ_HI.
- READ_HI: mac_hl=1; capture mac_out into res_data[33:17]; go to DONE.
- DONE: res_valid=1 with res_data and res_error held stable. On res_ready, go to IDLE. cmd_ready stays 0 until IDLE.
- Arithmetic: the sum wraps modulo 2^34 inside the MAC. The sequencer does no arithmetic beyond the counter.
- Reset asserted mid-job: immediate return to IDLE and the job is discarded. The MAC accumulator is not touched by reset; the next job's CLEAR cycle empties it.

## Timing
- Reset values: cmd_ready=1, op_ready=0, res_valid=0, res_data=0, res_error=0, mac_clear=0, mac_a=mac_b=0, mac_hl=0.
- All outputs other than mac_a/mac_b are decoded from registered state. mac_a/mac_b are combinational from op_*, gated by state.
- Cycle numbering, with the cmd handshake in cycle 0:
  - cycle 1: CLEAR
  - cycles 2..N+1: STREAM, given a gap-free stream of N pairs
  - cycle N+2: READ_LO
  - cycle N+3: READ_HI
  - cycle N+4: res_valid rises
- Throughput: one pair per cycle in STREAM.
- The next cmd is accepted no earlier than the cycle after the res handshake.

## Structure
- Package tpu_seq_pkg holds:
  - state enum
  - OP_W=8, ACC_W=34, HALF_W=17
  - ZERO_OP=8'h00
- One sub-module, seq_pair_counter: a loadable down-counter with a terminal-count flag.

## Test plan
- cmd_len=0, pair (8'h08, 8'h08): res_data=34'h40, res_error=0, res_valid in cycle 5.
- cmd_len=1, pairs (08,08),(08,08) with op_valid low for 3 cycles between them: res_data=34'h80; the bubbles add nothing.
- cmd_len=0, pair (8'h88, 8'h08): res_data=34'h3_FFFF_FFC0. Cycle-check that mac_out is 17'h1FFC0 in READ_LO and 17'h1FFFF in READ_HI.
- Two back-to-back jobs, (08,08) then (88,08): second result is 34'h3_FFFF_FFC0. The CLEAR cycle must discard the prior 34'h40.
- Pair (8'h7F, 8'h7F) mid-job: res_error=1. The next job with benign operands returns res_error=0.
- Reset pulsed during STREAM, then a new job (08,08): the FSM is in IDLE immediately and the new result is 34'h40. res_ready held low during DONE keeps res_valid and res_data stable.
